// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory, the fetch stage and the loader.
package imem_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 20;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Word address +1, wrapped to a w-bit address space (carry dropped).
  function automatic logic [31:0] addr_inc(input logic [31:0] a, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (a + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/imem_fetch2_clear_seq.sv
// Post-reset clear sequencer: sweeps addresses 0..CLEAR_WORDS-1, then enters RUN.
module imem_clear_seq
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned CLEAR_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLEAR_WORDS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;

  // State and sweep counter register; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  // Advance the sweep; the last word is cleared on the edge that enters RUN.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_n = clr_cnt + 1'b1;
      if (clr_cnt == LAST) state_n = RUN;
    end
  end

  assign ready    = (state == RUN);
  assign clr_en   = (state == CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/imem_fetch2.sv
// Instruction memory returning two consecutive words per fetch, with a
// download write port, post-reset clear and a registered read path.
module imem_fetch2
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned CLEAR_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic              port_wr;
  logic              hit0, hit1;

  imem_clear_seq #(
    .ADDR_W      (ADDR_W),
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign rd_addr1 = ADDR_W'(addr_inc(32'(rd_addr), ADDR_W));
  assign port_wr  = ready && wr_en;
  assign hit0     = port_wr && (wr_addr == rd_addr);
  assign hit1     = port_wr && (wr_addr == rd_addr1);

  // Storage writes: clear sweep during CLEAR, download port during RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en)       mem[clr_addr] <= '0;
      else if (port_wr) mem[wr_addr]  <= wr_data;
    end
  end

  // Registered dual read with write-through bypass on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else if (ready && rd_req) begin
      rd_valid <= 1'b1;
      rd_data0 <= hit0 ? wr_data : mem[rd_addr];
      rd_data1 <= hit1 ? wr_data : mem[rd_addr1];
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/imem_fetch2.md
# imem_fetch2

Parametrised instruction memory for the pipelined processor's fetch stage. It returns two consecutive words per request, so one fetch covers both single-word and double-word (immediate-carrying) instructions. It has a separate load/write port for program download and clears a configurable region after reset using a sequencer. A `ready` flag tells fetch when the memory can be used, and a registered read path with a `valid` pulse replaces ad-hoc clock-edge reads.

## Interface
- DATA_W, 16, instruction word width in bits
- ADDR_W, 20, word-address width; depth is 2^ADDR_W words
- CLEAR_WORDS, 8, number of words zeroed after reset, starting at address 0; legal range 1..2^ADDR_W

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high when the clear sequence is done and requests are accepted
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- rd_req  in  1  fetch request
- rd_addr  in  ADDR_W  fetch word address
- rd_valid  out  1  one-cycle pulse marking new rd_data0/rd_data1
- rd_data0  out  DATA_W  mem[rd_addr]
- rd_data1  out  DATA_W  mem[(rd_addr+1) mod 2^ADDR_W]

## Operation
- FSM states: CLEAR, RUN.
- rst high at an edge:
  - state goes to CLEAR and clr_cnt goes to 0.
  - ready=0, rd_valid=0, rd_data0=0, rd_data1=0.
  - No memory write happens on that edge.
- CLEAR, each edge with rst low:
  - mem[clr_cnt] <= 0, then clr_cnt increments.
  - When clr_cnt == CLEAR_WORDS-1, the last word is written on that edge and the FSM moves to RUN with ready=1.
- CLEAR: wr_en and rd_req are ignored. No write happens, and rd_valid stays 0.
- RUN: wr_en=1 writes mem[wr_addr] <= wr_data.
- RUN: rd_req=1 captures both words into rd_data0/rd_data1 and sets rd_valid=1 on the next edge.
- RUN: rd_req=0 sets rd_valid=0 on the next edge. rd_data0/rd_data1 hold their last values.
- Wrap-around: rd_addr = 2^ADDR_W-1 returns rd_data1 = mem[0]. The address arithmetic is ADDR_W bits wide and drops the carry.
- Write/read collision on the same edge:
  - If wr_addr equals rd_addr, rd_data0 returns wr_data (write-through).
  - If wr_addr equals rd_addr+1 (after wrap), rd_data1 returns wr_data.
  - Both can match only when the depth is 1 word; that configuration is not supported.
- Contents outside [0, CLEAR_WORDS-1] are not initialised by reset. They are undefined until written.
- rst mid-clear restarts the sweep at 0. rst in RUN drops ready and rd_valid on that same edge, and a request made on that edge is discarded.

## Timing
- Read latency: 1 cycle, from the rd_req edge to rd_valid/data. Back-to-back requests sustain 1 fetch per cycle.
- Write latency: 1 cycle. A read requested on the edge after a write returns the new data.
- Clear duration: ready rises CLEAR_WORDS edges after the first edge at which rst is low.
- Reset values: ready=0, rd_valid=0, rd_data0=0, rd_data1=0, state=CLEAR, clr_cnt=0.
- There is no back-pressure. Fetch must gate rd_req with ready. Requests made while ready=0 are dropped silently.

## Structure
- Package imem_pkg holds:
  - the state enum {CLEAR, RUN};
  - default DATA_W/ADDR_W constants shared with the fetch stage and the loader;
  - an ADDR_INC helper that does the wrapping +1.
- Sub-module imem_clear_seq is natural: it owns the state register, clr_cnt and ready, and produces the clear write address and enable.
- The top level holds the storage array, the write mux (clear vs. port), the registered dual read, and the bypass compare.

## Test plan
- Reset, CLEAR_WORDS=8:
  - Preload mem[3]=16'hBEEF, assert rst for 2 cycles, then release.
  - ready must rise exactly 8 edges after release, and a fetch at 3 must return 16'h0000/16'h0000.
- Basic fetch:
  - Write mem[10]=16'h1234 and mem[11]=16'h5678, then rd_req at 10.
  - The next cycle must show rd_valid=1, rd_data0=16'h1234, rd_data1=16'h5678.
  - With rd_req low the cycle after, rd_valid must be 0 and the data must hold.
- Wrap-around, ADDR_W=4:
  - mem[15]=16'hAAAA, mem[0]=16'h5555, fetch at 15.
  - Must return 16'hAAAA/16'h5555.
- Collision:
  - On the same edge, write 16'hCAFE to 21 and fetch at 20 (old mem[20]=16'h0001).
  - Must return 16'h0001/16'hCAFE.
- Requests during clear:
  - Pulse rd_req and wr_en (mem[2]=16'hFFFF) while ready=0.
  - rd_valid must stay 0, and a fetch at 2 after ready=1 must return 16'h0000.
- Mid-operation reset:
  - Issue continuous fetches in RUN and assert rst for one cycle.
  - rd_valid must be 0 the following cycle, ready must stay 0 for CLEAR_WORDS edges, and fetches must resume afterwards.
